// File: rtl/twofish_subkey_gen.sv
// Twofish 128-bit key schedule: one K[2i]/K[2i+1] pair per cycle into a 40-word
// register file, served through a registered read port.
module h_function (
  input  logic [31:0] x,
  input  logic [31:0] l0,
  input  logic [31:0] l1,
  output logic [31:0] z
);
  // Nibble tables t0..t3 for q0 (index 0) and q1 (index 1).
  localparam logic [3:0] QT [2][4][16] = '{
    '{'{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4},
      '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD},
      '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1},
      '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA}},
    '{'{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5},
      '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8},
      '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF},
      '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA}}
  };

  localparam logic [7:0] MDS [4][4] = '{
    '{8'h01, 8'hEF, 8'h5B, 8'h5B},
    '{8'h5B, 8'hEF, 8'hEF, 8'h01},
    '{8'hEF, 8'h5B, 8'h01, 8'hEF},
    '{8'hEF, 8'h01, 8'hEF, 8'h5B}
  };

  function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] xb);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = xb[7:4];
    b0 = xb[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b000};
    a2 = QT[sel][0][a1];
    b2 = QT[sel][1][b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    a4 = QT[sel][2][a3];
    b4 = QT[sel][3][b3];
    return {b4, a4};
  endfunction

  // GF(2^8) multiply modulo x^8+x^6+x^5+x^3+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h69 : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] y [4];

  assign y[0] = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, x[7:0])   ^ l1[7:0])   ^ l0[7:0]);
  assign y[1] = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, x[15:8])  ^ l1[15:8])  ^ l0[15:8]);
  assign y[2] = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, x[23:16]) ^ l1[23:16]) ^ l0[23:16]);
  assign y[3] = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, x[31:24]) ^ l1[31:24]) ^ l0[31:24]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_mds
    assign z[8*gi +: 8] = gf_mul(MDS[gi][0], y[0]) ^ gf_mul(MDS[gi][1], y[1]) ^
                          gf_mul(MDS[gi][2], y[2]) ^ gf_mul(MDS[gi][3], y[3]);
  end
endmodule

module twofish_subkey_gen #(
  parameter int          NUM_SUBKEYS = 40,
  parameter logic [31:0] RHO         = 32'h01010101
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         ready,
  input  logic [5:0]   k_rd_addr,
  output logic [31:0]  k_rd_data
);
  localparam int              IW       = $clog2(NUM_SUBKEYS / 2);
  localparam logic [IW-1:0]   LAST     = IW'(NUM_SUBKEYS / 2 - 1);
  localparam logic [5:0]      NUM_WORD = 6'(NUM_SUBKEYS);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t          state_reg, state_next;
  logic [127:0]    key_reg;
  logic [IW-1:0]   i_reg;
  logic            done_reg;
  logic            accept, wr_en;
  logic [31:0]     k_mem [NUM_SUBKEYS];
  logic [31:0]     a_word, b_raw, b_word, sum2, k_even, k_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (i_reg == LAST) state_next = READY;
      READY:   if (start) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg == EXPAND);
    ready  = (state_reg == READY);
    wr_en  = (state_reg == EXPAND);
    accept = start && (state_reg != EXPAND);
  end

  assign done = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg  <= '0;
      i_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= wr_en && (i_reg == LAST);
      if (accept) begin
        key_reg <= key;
        i_reg   <= '0;
      end else if (wr_en && (i_reg != LAST)) begin
        i_reg <= i_reg + 1'b1;
      end
    end
  end

  h_function u_h_even (
    .x  (RHO * 32'({i_reg, 1'b0})),
    .l0 (key_reg[31:0]),
    .l1 (key_reg[95:64]),
    .z  (a_word)
  );

  h_function u_h_odd (
    .x  (RHO * 32'({i_reg, 1'b1})),
    .l0 (key_reg[63:32]),
    .l1 (key_reg[127:96]),
    .z  (b_raw)
  );

  // PHT on A and ROL8(B), then ROL9 on the odd word.
  assign b_word = {b_raw[23:0], b_raw[31:24]};
  assign k_even = a_word + b_word;
  assign sum2   = a_word + {b_word[30:0], 1'b0};
  assign k_odd  = {sum2[22:0], sum2[31:23]};

  for (genvar gi = 0; gi < NUM_SUBKEYS; gi++) begin : g_kfile
    localparam logic [IW-1:0] PAIR = IW'(gi / 2);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        k_mem[gi] <= '0;
      else if (wr_en && (i_reg == PAIR))
        k_mem[gi] <= (gi % 2 == 0) ? k_even : k_odd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    k_rd_data <= '0;
    else if (k_rd_addr < NUM_WORD) k_rd_data <= k_mem[k_rd_addr];
    else                           k_rd_data <= '0;
  end
endmodule

// File: tb/tb_twofish_subkey_gen.sv
// Self-checking bench for twofish_subkey_gen against a software Twofish key-schedule model.
module tb_twofish_subkey_gen;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key;
  logic         busy, done, ready;
  logic [5:0]   k_rd_addr;
  logic [31:0]  k_rd_data;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] ref_k [40];
  logic [31:0] prev39 = 32'h0;

  int qt [2][4][16] = '{
    '{'{'h8,'h1,'h7,'hD,'h6,'hF,'h3,'h2,'h0,'hB,'h5,'h9,'hE,'hC,'hA,'h4},
      '{'hE,'hC,'hB,'h8,'h1,'h2,'h3,'h5,'hF,'h4,'hA,'h6,'h7,'h0,'h9,'hD},
      '{'hB,'hA,'h5,'hE,'h6,'hD,'h9,'h0,'hC,'h8,'hF,'h3,'h2,'h4,'h7,'h1},
      '{'hD,'h7,'hF,'h4,'h1,'h2,'h6,'hE,'h9,'hB,'h3,'h0,'h8,'h5,'hC,'hA}},
    '{'{'h2,'h8,'hB,'hD,'hF,'h7,'h6,'hE,'h3,'h1,'h9,'h4,'h0,'hA,'hC,'h5},
      '{'h1,'hE,'h2,'hB,'h4,'hC,'h3,'h7,'h6,'hD,'hA,'h5,'hF,'h9,'h0,'h8},
      '{'h4,'hC,'h7,'h5,'h1,'h6,'h9,'hA,'h0,'hE,'hD,'h8,'h2,'hB,'h3,'hF},
      '{'hB,'h9,'h5,'h1,'hC,'h3,'hD,'hE,'h6,'h4,'h7,'hF,'h2,'h0,'h8,'hA}}
  };
  int mds [4][4] = '{'{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                     '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B}};

  twofish_subkey_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .ready     (ready),
    .k_rd_addr (k_rd_addr),
    .k_rd_data (k_rd_data)
  );

  always #5 clk = ~clk;

  function automatic int ror4(int v);
    return ((v >> 1) | ((v & 1) << 3)) & 15;
  endfunction

  function automatic int m_q(int sel, int x);
    int a0, b0, a1, b1, a2, b2, a3, b3;
    a0 = (x >> 4) & 15;  b0 = x & 15;
    a1 = a0 ^ b0;        b1 = a0 ^ ror4(b0) ^ ((8 * a0) % 16);
    a2 = qt[sel][0][a1]; b2 = qt[sel][1][b1];
    a3 = a2 ^ b2;        b3 = a2 ^ ror4(b2) ^ ((8 * a2) % 16);
    return 16 * qt[sel][3][b3] + qt[sel][2][a3];
  endfunction

  // Polynomial product, then reduction by 0x169.
  function automatic int m_gf(int a, int b);
    int p = 0;
    for (int n = 0; n < 8; n++) if ((b >> n) & 1) p = p ^ (a << n);
    for (int bit_i = 14; bit_i >= 8; bit_i--) if ((p >> bit_i) & 1) p = p ^ ('h169 << (bit_i - 8));
    return p;
  endfunction

  function automatic logic [31:0] m_h(int xb, logic [31:0] l0, logic [31:0] l1);
    int first [4]  = '{0, 1, 0, 1};
    int second [4] = '{0, 0, 1, 1};
    int third [4]  = '{1, 0, 1, 0};
    int y [4];
    logic [31:0] zz = 32'h0;
    for (int j = 0; j < 4; j++) begin
      y[j] = m_q(first[j], xb);
      y[j] = m_q(second[j], y[j] ^ int'(l1[8*j +: 8]));
      y[j] = m_q(third[j], y[j] ^ int'(l0[8*j +: 8]));
    end
    for (int r = 0; r < 4; r++) begin
      int acc = 0;
      for (int c = 0; c < 4; c++) acc = acc ^ m_gf(mds[r][c], y[c]);
      zz = zz | (32'(acc) << (8 * r));
    end
    return zz;
  endfunction

  function automatic logic [31:0] rol(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] a, b;
    for (int p = 0; p < 20; p++) begin
      a = m_h(2 * p, k[31:0], k[95:64]);
      b = rol(m_h(2 * p + 1, k[63:32], k[127:96]), 8);
      ref_k[2*p]   = a + b;
      ref_k[2*p+1] = rol(a + 2 * b, 9);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    k_rd_addr = 6'(a);
    tick();
    d = k_rd_data;
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Accepts k, optionally pulses start at cycles pa/pb, optionally stops at cycle stop_at.
  task automatic expand(input logic [127:0] k, input int pa, input int pb, input int stop_at);
    int cycles = 0;
    compute_model(k);
    k_rd_addr = 6'd39;
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = rnd_key();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(ready), 32'd0);
    while (cycles < 40) begin
      tick();
      cycles++;
      if (cycles == 1) chk("read_old_k39", k_rd_data, prev39);
      if (cycles == stop_at) return;
      if (cycles == pa || cycles == pb) begin
        start = 1'b1;
        key = rnd_key();
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    chk("done_latency", 32'(cycles), 32'd20);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("ready_at_done", 32'(ready), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    prev39 = ref_k[39];
  endtask

  task automatic verify_all(input bit high_addrs);
    logic [31:0] d;
    for (int a = 0; a < 40; a++) begin
      rd(a, d);
      chk($sformatf("k%0d", a), d, ref_k[a]);
    end
    if (high_addrs)
      for (int a = 40; a < 64; a++) begin
        rd(a, d);
        chk($sformatf("addr%0d_zero", a), d, 32'h0);
      end
  endtask

  initial begin
    logic [31:0] d;
    logic [127:0] k1, k2;
    rst_n = 1'b0; start = 1'b0; key = '0; k_rd_addr = 6'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd_data", k_rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, d);  chk("rst_k0", d, 32'h0);
    rd(17, d); chk("rst_k17", d, 32'h0);
    rd(39, d); chk("rst_k39", d, 32'h0);

    // All-zero key with published subkeys.
    expand(128'h0, -1, -1, -1);
    rd(0, d); chk("kat_k0", d, 32'h52C54DDE);
    rd(1, d); chk("kat_k1", d, 32'h11F0626D);
    rd(2, d); chk("kat_k2", d, 32'h7CAC9D4A);
    rd(3, d); chk("kat_k3", d, 32'h4D1B4AAA);
    verify_all(1'b0);

    for (int t = 0; t < 3; t++) begin
      expand(rnd_key(), -1, -1, -1);
      verify_all(t == 0);
    end

    // start while busy is ignored.
    k1 = rnd_key();
    expand(k1, 3, 10, -1);
    verify_all(1'b0);

    // Reset in the middle of an expansion.
    expand(rnd_key(), -1, -1, 9);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rd_data", k_rd_data, 32'h0);
    tick();
    rst_n = 1'b1;
    prev39 = 32'h0;
    rd(0, d);  chk("midrst_k0", d, 32'h0);
    rd(39, d); chk("midrst_k39", d, 32'h0);
    chk("midrst_ready_held", 32'(ready), 32'd0);
    expand(rnd_key(), -1, -1, -1);
    verify_all(1'b0);

    // Restart directly from READY.
    k2 = rnd_key();
    expand(k2, -1, -1, -1);
    rd(0, d); chk("restart_k0", d, ref_k[0]);
    verify_all(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "timeout");
  end
endmodule
